// File: rtl/coherence_bus_ctrl_if.sv
// rtl/coherence_bus_ctrl_if.sv - cache and RAM signal bundle for the coherence bus controller
interface coherence_bus_ctrl_if #(
  parameter int CPUS = 2
);
  // instruction side, one lane per core
  logic [CPUS-1:0]      iREN;
  logic [CPUS*32-1:0]   iaddr;
  logic [CPUS*32-1:0]   iload;
  logic [CPUS-1:0]      iwait;
  // data side, one lane per core
  logic [CPUS-1:0]      dREN;
  logic [CPUS-1:0]      dWEN;
  logic [CPUS*32-1:0]   daddr;
  logic [CPUS*32-1:0]   dstore;
  logic [CPUS*32-1:0]   dload;
  logic [CPUS-1:0]      dwait;
  // coherence handshake
  logic [CPUS-1:0]      cctrans;
  logic [CPUS-1:0]      ccwrite;
  logic [CPUS-1:0]      ccwait;
  logic [CPUS-1:0]      ccinv;
  logic [CPUS*32-1:0]   ccsnoopaddr;
  // shared RAM port; ramstate encoding FREE=0, BUSY=1, ACCESS=2, ERROR=3
  logic                 ramREN;
  logic                 ramWEN;
  logic [31:0]          ramaddr;
  logic [31:0]          ramstore;
  logic [31:0]          ramload;
  logic [1:0]           ramstate;

  // controller side
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    output iload, iwait, dload, dwait, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );

  // caches plus RAM model side
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    input  iload, iwait, dload, dwait, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// rtl/coherence_bus_ctrl.sv - snooping coherence bus controller and round-robin RAM arbiter
module coherence_bus_ctrl #(
  parameter int CPUS        = 2,
  parameter int BLOCK_WORDS = 2
) (
  input logic                 CLK,
  input logic                 nRST,
  coherence_bus_ctrl_if.slave bus
);

  localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int CW = $clog2(BLOCK_WORDS) + 1;

  // only ACCESS produces a beat; FREE, BUSY and ERROR all mean "keep waiting"
  localparam logic [1:0]    ACCESS    = 2'd2;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BLOCK_WORDS - 1);
  localparam logic [IW-1:0] LAST_CPU  = IW'(CPUS - 1);

  typedef enum logic [2:0] {IDLE, SNOOP, C2C, DRAM, IRAM} state_t;

  state_t         state;
  logic [IW-1:0]  g;
  logic [IW-1:0]  r;
  logic [IW-1:0]  dptr;
  logic [IW-1:0]  iptr;
  logic [CW-1:0]  cnt;

  logic [31:0]    daddr_w  [CPUS];
  logic [31:0]    dstore_w [CPUS];
  logic [31:0]    iaddr_w  [CPUS];

  logic [CPUS-1:0] dreq_v;
  logic [IW-1:0]   dsel;
  logic [IW-1:0]   isel;
  logic [IW-1:0]   rsel;
  logic            rany;
  logic            greq;
  logic            ireq;
  logic            beat;

  // unpack the per-core word buses so the granted lane can be indexed directly
  for (genvar k = 0; k < CPUS; k++) begin : g_lane
    assign daddr_w[k]  = bus.daddr[k*32 +: 32];
    assign dstore_w[k] = bus.dstore[k*32 +: 32];
    assign iaddr_w[k]  = bus.iaddr[k*32 +: 32];
  end

  // first requester at or after ptr, wrapping modulo CPUS
  function automatic logic [IW-1:0] rr_pick(input logic [CPUS-1:0] req, input logic [IW-1:0] ptr);
    logic [IW-1:0] pick;
    logic          found;
    int            k;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < CPUS; i++) begin
      k = int'(ptr) + i;
      if (k >= CPUS) k = k - CPUS;
      if (!found && req[k]) begin
        pick  = IW'(k);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // successor of a core index, wrapping modulo CPUS
  function automatic logic [IW-1:0] next_core(input logic [IW-1:0] p);
    return (p == LAST_CPU) ? '0 : p + 1'b1;
  endfunction

  assign dreq_v = bus.dREN | bus.dWEN;
  assign dsel   = rr_pick(dreq_v, dptr);
  assign isel   = rr_pick(bus.iREN, iptr);
  assign greq   = bus.dREN[g] | bus.dWEN[g];
  assign ireq   = bus.iREN[g];
  assign beat   = (bus.ramstate == ACCESS);

  // lowest non-requesting core that reports a dirty hit during the snoop
  always_comb begin
    rsel = '0;
    rany = 1'b0;
    for (int j = 0; j < CPUS; j++) begin
      if (!rany && (IW'(j) != g) && bus.ccwrite[j]) begin
        rsel = IW'(j);
        rany = 1'b1;
      end
    end
  end

  // transaction sequencing, grant bookkeeping and round-robin pointer update
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      g     <= '0;
      r     <= '0;
      cnt   <= '0;
      dptr  <= '0;
      iptr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|dreq_v) begin
            g     <= dsel;
            cnt   <= '0;
            state <= bus.cctrans[dsel] ? SNOOP : DRAM;
          end else if (|bus.iREN) begin
            g     <= isel;
            state <= IRAM;
          end
        end
        SNOOP: begin
          if (!greq) begin
            state <= IDLE;
            dptr  <= next_core(g);
          end else if (rany) begin
            r     <= rsel;
            state <= C2C;
          end else begin
            state <= DRAM;
          end
        end
        C2C, DRAM: begin
          if (!greq) begin
            state <= IDLE;
            dptr  <= next_core(g);
          end else if (beat) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) begin
              state <= IDLE;
              dptr  <= next_core(g);
            end
          end
        end
        IRAM: begin
          if (!ireq || beat) begin
            state <= IDLE;
            iptr  <= next_core(g);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // bus, snoop and RAM drive decoded from the current state; beats release waits combinationally
  always_comb begin
    bus.iwait       = '1;
    bus.dwait       = '1;
    bus.ccwait      = '0;
    bus.ccinv       = '0;
    bus.ccsnoopaddr = '0;
    bus.iload       = '0;
    bus.dload       = '0;
    bus.ramREN      = 1'b0;
    bus.ramWEN      = 1'b0;
    bus.ramaddr     = '0;
    bus.ramstore    = '0;
    case (state)
      SNOOP: begin
        for (int j = 0; j < CPUS; j++) begin
          if (IW'(j) != g) begin
            bus.ccwait[j]             = 1'b1;
            bus.ccinv[j]              = bus.ccwrite[g];
            bus.ccsnoopaddr[j*32 +: 32] = daddr_w[g];
          end
        end
      end
      C2C: begin
        bus.ramWEN   = 1'b1;
        bus.ramaddr  = daddr_w[r];
        bus.ramstore = dstore_w[r];
        for (int j = 0; j < CPUS; j++) begin
          if (IW'(j) != g) begin
            bus.ccwait[j] = 1'b1;
            bus.ccinv[j]  = bus.ccwrite[g];
          end else begin
            bus.dload[j*32 +: 32] = dstore_w[r];
          end
        end
        if (beat) begin
          bus.dwait[g] = 1'b0;
          bus.dwait[r] = 1'b0;
        end
      end
      DRAM: begin
        bus.ramaddr = daddr_w[g];
        if (bus.dWEN[g]) begin
          bus.ramWEN   = 1'b1;
          bus.ramstore = dstore_w[g];
        end else begin
          bus.ramREN = 1'b1;
          for (int j = 0; j < CPUS; j++) begin
            if (IW'(j) == g) bus.dload[j*32 +: 32] = bus.ramload;
          end
        end
        if (beat) bus.dwait[g] = 1'b0;
      end
      IRAM: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = iaddr_w[g];
        for (int j = 0; j < CPUS; j++) begin
          if (IW'(j) == g) bus.iload[j*32 +: 32] = bus.ramload;
        end
        if (beat) bus.iwait[g] = 1'b0;
      end
      default: ;
    endcase
  end

  // the RAM port is never asked to read and write at once
  a_ram_excl: assert property (@(posedge CLK) disable iff (!nRST) !(bus.ramREN && bus.ramWEN));

  // a cache-to-cache responder is never the requester itself
  a_resp_ne_req: assert property (@(posedge CLK) disable iff (!nRST) (state == C2C) |-> (r != g));

  // the requester is never snooped or invalidated
  a_no_self_snoop: assert property (@(posedge CLK) disable iff (!nRST)
    (state != IDLE) |-> !(bus.ccwait[g] || bus.ccinv[g]));

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb/tb_coherence_bus_ctrl.sv - vector table plus scoreboarded sequences for coherence_bus_ctrl
module tb_coherence_bus_ctrl;
  localparam int CPUS = 4;
  localparam int BW   = 2;
  localparam logic [1:0] BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  localparam logic [31:0] RAMKEY = 32'hC0DE_0000;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  coherence_bus_ctrl_if #(.CPUS(CPUS)) bus ();
  coherence_bus_ctrl #(.CPUS(CPUS), .BLOCK_WORDS(BW)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  // RAM model: read data is a fixed function of the address
  assign bus.ramload = bus.ramaddr ^ RAMKEY;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [3:0] dren, dwen, iren, cct, ccw;
    logic [3:0] x_dwait, x_iwait, x_ccwait, x_ccinv;
    logic       x_ren, x_wen;
    logic [31:0] x_addr;
  } vec_t;

  typedef struct {
    logic [3:0]  dwait, iwait;
    logic        ren, wen;
    logic [31:0] addr;
    int          lcore;
    bit          instr;
    logic [31:0] load;
  } beat_t;

  vec_t  tbl [8];
  beat_t sbq [$];

  int          dleft [CPUS];
  int          rleft [CPUS];
  int          ileft [CPUS];
  bit          armed [CPUS];
  logic [31:0] raddr [CPUS];
  logic [31:0] rdata [CPUS];
  logic [3:0]  x_ccwait, x_ccinv;
  logic [31:0] x_snaddr;
  int          snoops;
  int          busy_cnt;
  logic [1:0]  busy_kind;
  bit          mon_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr();
    bus.iREN = '0; bus.iaddr = '0; bus.dREN = '0; bus.dWEN = '0;
    bus.daddr = '0; bus.dstore = '0; bus.cctrans = '0; bus.ccwrite = '0;
    bus.ramstate = ACCESS;
    busy_cnt = 0;
    for (int k = 0; k < CPUS; k++) begin
      dleft[k] = 0; rleft[k] = 0; ileft[k] = 0; armed[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    clr();
    sbq.delete();
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  function automatic bit model_idle();
    for (int k = 0; k < CPUS; k++)
      if (dleft[k] != 0 || rleft[k] != 0 || ileft[k] != 0 || armed[k]) return 1'b0;
    return 1'b1;
  endfunction

  // one clock: observe at negedge, then apply the cache-model reaction just after the posedge
  task automatic tick();
    logic [3:0] dw, iw;
    beat_t      e;
    @(negedge CLK);
    dw = bus.dwait;
    iw = bus.iwait;
    if (mon_en) begin
      chk("ram_rw_exclusive", 32'(bus.ramREN & bus.ramWEN), 32'd0);
      chk("wait_low_count_le2", 32'(($countones(~dw) + $countones(~iw)) > 2), 32'd0);
      if (bus.ccwait != '0) begin
        chk("ccwait", 32'(bus.ccwait), 32'(x_ccwait));
        chk("ccinv", 32'(bus.ccinv), 32'(x_ccinv));
        if (bus.ccsnoopaddr != '0) begin
          snoops++;
          for (int j = 0; j < CPUS; j++)
            if (x_ccwait[j]) chk("ccsnoopaddr", bus.ccsnoopaddr[j*32 +: 32], x_snaddr);
        end
      end
      if ((~dw | ~iw) != '0) begin
        if (sbq.size() == 0) begin
          chk("unexpected_beat", 32'({iw, dw}), 32'hFF);
        end else begin
          e = sbq.pop_front();
          chk("beat_dwait", 32'(dw), 32'(e.dwait));
          chk("beat_iwait", 32'(iw), 32'(e.iwait));
          chk("beat_ramREN", 32'(bus.ramREN), 32'(e.ren));
          chk("beat_ramWEN", 32'(bus.ramWEN), 32'(e.wen));
          chk("beat_ramaddr", bus.ramaddr, e.addr);
          if (e.lcore >= 0) begin
            if (e.instr) chk("beat_iload", bus.iload[e.lcore*32 +: 32], e.load);
            else         chk("beat_dload", bus.dload[e.lcore*32 +: 32], e.load);
          end
        end
      end
      // a dirty cache answers the snoop before the sampling edge
      for (int k = 0; k < CPUS; k++) begin
        if (bus.ccwait[k] && armed[k]) begin
          armed[k] = 1'b0;
          bus.ccwrite[k] = 1'b1;
          bus.dWEN[k] = 1'b1;
          bus.daddr[k*32 +: 32] = raddr[k];
          bus.dstore[k*32 +: 32] = rdata[k];
          rleft[k] = BW;
        end
      end
    end
    @(posedge CLK); #1;
    for (int k = 0; k < CPUS; k++) begin
      if (!dw[k]) begin
        if (rleft[k] > 0) begin
          rleft[k]--;
          bus.daddr[k*32 +: 32]  = bus.daddr[k*32 +: 32] + 32'd4;
          bus.dstore[k*32 +: 32] = bus.dstore[k*32 +: 32] + 32'd1;
          if (rleft[k] == 0) begin bus.dWEN[k] = 1'b0; bus.ccwrite[k] = 1'b0; end
        end else if (dleft[k] > 0) begin
          dleft[k]--;
          bus.daddr[k*32 +: 32] = bus.daddr[k*32 +: 32] + 32'd4;
          if (dleft[k] == 0) begin
            bus.dREN[k] = 1'b0; bus.dWEN[k] = 1'b0; bus.cctrans[k] = 1'b0; bus.ccwrite[k] = 1'b0;
          end
        end
      end
      if (!iw[k] && ileft[k] > 0) begin
        ileft[k]--;
        bus.iREN[k] = 1'b0;
      end
    end
    if (busy_cnt > 0) begin
      bus.ramstate = busy_kind;
      busy_cnt--;
    end else begin
      bus.ramstate = ACCESS;
    end
  endtask

  task automatic run(input string name, input int exp_cyc);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!model_idle() && n < 100);
    chk({name, "_cycles"}, 32'(n), 32'(exp_cyc));
    chk({name, "_sb_empty"}, 32'(sbq.size()), 32'd0);
  endtask

  task automatic dreq(input int c, input logic [31:0] a, input bit cct, input bit ccw);
    bus.dREN[c] = 1'b1;
    bus.cctrans[c] = cct;
    bus.ccwrite[c] = ccw;
    bus.daddr[c*32 +: 32] = a;
    dleft[c] = BW;
  endtask

  task automatic push_dread(input int c, input logic [31:0] a);
    for (int i = 0; i < BW; i++)
      sbq.push_back('{dwait: ~(4'b1 << c), iwait: 4'hF, ren: 1'b1, wen: 1'b0,
                      addr: a + 32'(4*i), lcore: c, instr: 1'b0, load: (a + 32'(4*i)) ^ RAMKEY});
  endtask

  task automatic push_c2c(input int gc, input int rc, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < BW; i++)
      sbq.push_back('{dwait: ~((4'b1 << gc) | (4'b1 << rc)), iwait: 4'hF, ren: 1'b0, wen: 1'b1,
                      addr: a + 32'(4*i), lcore: gc, instr: 1'b0, load: d + 32'(i)});
  endtask

  task automatic push_iread(input int c, input logic [31:0] a);
    sbq.push_back('{dwait: 4'hF, iwait: ~(4'b1 << c), ren: 1'b1, wen: 1'b0,
                    addr: a, lcore: c, instr: 1'b1, load: a ^ RAMKEY});
  endtask

  initial begin
    tbl[0] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1101, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'h1010};
    tbl[1] = '{4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1101, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'h1010};
    tbl[2] = '{4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'h1030};
    tbl[3] = '{4'b0000, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b1111, 4'b1110, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'h2000};
    tbl[4] = '{4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b1011, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 32'h1020};
    tbl[5] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b1111, 4'b1111, 4'b1110, 4'b1110, 1'b0, 1'b0, 32'h0};
    tbl[6] = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b1111, 4'b1111, 4'b1011, 4'b0000, 1'b0, 1'b0, 32'h0};
    tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0};

    mon_en = 1'b0;
    snoops = 0;
    busy_kind = BUSY;
    nRST = 1'b0;
    clr();

    // reset state
    @(negedge CLK);
    chk("rst_dwait", 32'(bus.dwait), 32'hF);
    chk("rst_iwait", 32'(bus.iwait), 32'hF);
    chk("rst_ccwait", 32'(bus.ccwait), 32'h0);
    chk("rst_ramREN", 32'(bus.ramREN), 32'h0);
    chk("rst_ramWEN", 32'(bus.ramWEN), 32'h0);
    chk("rst_ramaddr", bus.ramaddr, 32'h0);

    // first cycle after the grant, from pointers at zero
    foreach (tbl[v]) begin
      do_reset();
      for (int k = 0; k < CPUS; k++) begin
        bus.daddr[k*32 +: 32] = 32'h1000 + 32'(16*k);
        bus.iaddr[k*32 +: 32] = 32'h2000 + 32'(16*k);
      end
      bus.dREN = tbl[v].dren; bus.dWEN = tbl[v].dwen; bus.iREN = tbl[v].iren;
      bus.cctrans = tbl[v].cct; bus.ccwrite = tbl[v].ccw;
      @(posedge CLK);
      @(negedge CLK);
      chk($sformatf("vec%0d_dwait", v), 32'(bus.dwait), 32'(tbl[v].x_dwait));
      chk($sformatf("vec%0d_iwait", v), 32'(bus.iwait), 32'(tbl[v].x_iwait));
      chk($sformatf("vec%0d_ccwait", v), 32'(bus.ccwait), 32'(tbl[v].x_ccwait));
      chk($sformatf("vec%0d_ccinv", v), 32'(bus.ccinv), 32'(tbl[v].x_ccinv));
      chk($sformatf("vec%0d_ramREN", v), 32'(bus.ramREN), 32'(tbl[v].x_ren));
      chk($sformatf("vec%0d_ramWEN", v), 32'(bus.ramWEN), 32'(tbl[v].x_wen));
      chk($sformatf("vec%0d_ramaddr", v), bus.ramaddr, tbl[v].x_addr);
    end

    do_reset();
    mon_en = 1'b1;

    // round robin: core 1 alone moves dptr to 2, then 3 beats 1, then 2 beats 0
    dreq(1, 32'h0040, 1'b0, 1'b0); push_dread(1, 32'h0040);
    run("rr_single", 3);
    dreq(1, 32'h0050, 1'b0, 1'b0); dreq(3, 32'h0070, 1'b0, 1'b0);
    push_dread(3, 32'h0070); push_dread(1, 32'h0050);
    run("rr_pair_1_3", 6);
    dreq(0, 32'h0080, 1'b0, 1'b0); dreq(2, 32'h00A0, 1'b0, 1'b0);
    push_dread(2, 32'h00A0); push_dread(0, 32'h0080);
    run("rr_pair_0_2", 6);

    // BusRdX with no dirty responder: one snoop cycle then DRAM
    snoops = 0;
    x_ccwait = 4'b1110; x_ccinv = 4'b1110; x_snaddr = 32'h100;
    dreq(0, 32'h0100, 1'b1, 1'b1); push_dread(0, 32'h0100);
    run("snoop_dram", 4);
    chk("snoop_dram_snoops", 32'(snoops), 32'd1);

    // BusRd answered by dirty core 1: cache-to-cache with writeback
    snoops = 0;
    x_ccwait = 4'b1011; x_ccinv = 4'b0000; x_snaddr = 32'h200;
    armed[1] = 1'b1; raddr[1] = 32'h200; rdata[1] = 32'hDEAD_0001;
    dreq(2, 32'h0200, 1'b1, 1'b0); push_c2c(2, 1, 32'h200, 32'hDEAD_0001);
    run("c2c", 4);
    chk("c2c_snoops", 32'(snoops), 32'd1);

    // data wins over a same-cycle instruction request
    bus.iREN[0] = 1'b1; bus.iaddr[0 +: 32] = 32'h0300; ileft[0] = 1;
    dreq(1, 32'h0400, 1'b0, 1'b0);
    push_dread(1, 32'h0400); push_iread(0, 32'h0300);
    run("d_over_i", 5);

    // stalled RAM: five BUSY cycles, then five ERROR cycles
    busy_kind = BUSY; busy_cnt = 5;
    dreq(0, 32'h0500, 1'b0, 1'b0); push_dread(0, 32'h0500);
    run("ram_busy", 8);
    busy_kind = ERROR; busy_cnt = 5;
    dreq(2, 32'h0600, 1'b0, 1'b0); push_dread(2, 32'h0600);
    run("ram_error", 8);

    // reset in the middle of a cache-to-cache transfer
    x_ccwait = 4'b1011; x_ccinv = 4'b0000; x_snaddr = 32'h700;
    armed[1] = 1'b1; raddr[1] = 32'h700; rdata[1] = 32'hBEEF_0001;
    dreq(2, 32'h0700, 1'b1, 1'b0); push_c2c(2, 1, 32'h700, 32'hBEEF_0001);
    tick(); tick(); tick();
    nRST = 1'b0;
    #1;
    chk("midrst_dwait", 32'(bus.dwait), 32'hF);
    chk("midrst_ccwait", 32'(bus.ccwait), 32'h0);
    chk("midrst_ramWEN", 32'(bus.ramWEN), 32'h0);
    chk("midrst_ramaddr", bus.ramaddr, 32'h0);
    chk("midrst_dload", bus.dload[64 +: 32], 32'h0);
    do_reset();
    dreq(1, 32'h0810, 1'b0, 1'b0); dreq(3, 32'h0830, 1'b0, 1'b0);
    push_dread(1, 32'h0810); push_dread(3, 32'h0830);
    run("post_rst_rr", 6);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
